// File: rtl/pl_mem_lsu.sv
// pl_mem_lsu: memory-stage load/store unit on a req/ack word bus.
// Steers byte lanes, extends loads, flags faults and bus timeouts.
module pl_mem_lsu #(
    parameter int unsigned TIMEOUT         = 16,
    parameter logic [1:0]  RESULT_SRC_LOAD = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        AccFaultM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    // Last counter value before abort; unused when TIMEOUT is 0.
    localparam logic [7:0] TMO_LAST =
        (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nx;
    logic        access;
    logic        f3_ok;
    logic        misal;
    logic        go;
    logic        tmo_hit;
    logic [1:0]  off;
    logic [7:0]  cnt;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;
    logic [3:0]  be_nx;
    logic [31:0] wd_nx;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign off     = ALUResultM[1:0];
    assign access  = MemWriteM | (ResultSrcM == RESULT_SRC_LOAD);
    assign misal   = ((funct3M[1:0] == 2'b01) & off[0])
                   | ((funct3M[1:0] == 2'b10) & (off != 2'b00));
    assign go      = (state == S_IDLE) & access & ~AccFaultM;
    assign tmo_hit = (TIMEOUT != 0) && (cnt == TMO_LAST);
    assign shifted = bus_rdata >> {ld_off, 3'b000};

    // Legal size/sign codes; unsigned variants exist only for loads.
    always_comb begin
        case (funct3M)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~MemWriteM;
            default:                f3_ok = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data for the access size.
    always_comb begin
        be_nx = 4'b1111;
        wd_nx = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                be_nx = 4'b0001 << off;
                wd_nx = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_nx = off[1] ? 4'b1100 : 4'b0011;
                wd_nx = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    // Align the returned word and sign/zero extend by load type.
    always_comb begin
        case (ld_f3)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext = {24'd0, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext = {16'd0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next state: ack beats a timeout in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (go) state_nx = S_WAIT;
            S_WAIT:  if (bus_ack || tmo_hit) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Pipeline-facing outputs decoded from state and MEM inputs.
    always_comb begin
        AccFaultM = access & (state == S_IDLE) & (~f3_ok | misal);
        StallM    = ((state == S_IDLE) & access & ~AccFaultM)
                  | (state == S_WAIT);
    end

    // Bus registers, wait counter and load result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            ReadDataM <= 32'd0;
            BusErrM   <= 1'b0;
            cnt       <= 8'd0;
            ld_f3     <= 3'd0;
            ld_off    <= 2'd0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        bus_req   <= 1'b1;
                        bus_we    <= MemWriteM;
                        bus_addr  <= {ALUResultM[31:2], 2'b00};
                        bus_be    <= be_nx;
                        bus_wdata <= wd_nx;
                        cnt       <= 8'd0;
                        ld_f3     <= funct3M;
                        ld_off    <= off;
                    end
                end
                S_WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) ReadDataM <= ext;
                    end else if (tmo_hit) begin
                        bus_req   <= 1'b0;
                        ReadDataM <= 32'd0;
                        BusErrM   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_mem_lsu.sv
// tb_pl_mem_lsu: directed stimulus with queued expectations
// checked by an independent monitor on bus request and completion.
module tb_pl_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        AccFaultM;
    logic        BusErrM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];

    int checks = 0;
    int errors = 0;
    logic rst_q = 1'b0;
    logic prev_req = 1'b0;
    logic prev_stall = 1'b0;

    pl_mem_lsu #(.TIMEOUT(4), .RESULT_SRC_LOAD(2'b01)) dut (
        .clk(clk), .reset(reset),
        .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .funct3M(funct3M), .StallM(StallM), .ReadDataM(ReadDataM),
        .AccFaultM(AccFaultM), .BusErrM(BusErrM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Note when a reset edge just happened, so completion is not scored.
    always @(posedge clk) rst_q <= reset;

    // Monitor: score each new bus request and each transaction end.
    always @(negedge clk) begin
        if (!rst_q && bus_req === 1'b1 && prev_req !== 1'b1) begin
            chk("req_expected", 32'(bus_q.size() != 0), 32'd1);
            if (bus_q.size() != 0) begin
                bus_exp_t b;
                b = bus_q.pop_front();
                chk("bus_we", 32'(bus_we), 32'(b.we));
                chk("bus_addr", bus_addr, b.addr);
                chk("bus_be", 32'(bus_be), 32'(b.be));
                if (b.we) chk("bus_wdata", bus_wdata, b.wd);
            end
        end
        if (!rst_q && prev_stall === 1'b1 && StallM === 1'b0) begin
            chk("done_expected", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) begin
                done_exp_t d;
                d = done_q.pop_front();
                chk("done_rdata", ReadDataM, d.rd);
                chk("done_buserr", 32'(BusErrM), 32'(d.err));
                chk("done_req_low", 32'(bus_req), 32'd0);
            end
        end
        prev_req   = bus_req;
        prev_stall = StallM;
    end

    task automatic drive(input logic we, input logic [1:0] rs,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3);
        MemWriteM  = we;
        ResultSrcM = rs;
        ALUResultM = a;
        WriteDataM = wd;
        funct3M    = f3;
    endtask

    // One legal access; ack arrives in WAIT cycle dly, or never.
    task automatic do_access(
        input string nm, input logic we, input logic [1:0] rs,
        input logic [31:0] a, input logic [31:0] wd,
        input logic [2:0] f3, input logic ack_en, input int dly,
        input logic [31:0] rdata, input logic [31:0] e_addr,
        input logic [3:0] e_be, input logic [31:0] e_wd,
        input logic [31:0] e_rd);
        bus_exp_t  b;
        done_exp_t d;
        int stalls;
        int reqs;
        tick();
        drive(we, rs, a, wd, f3);
        bus_ack   = 1'b0;
        bus_rdata = rdata;
        b.we = we; b.addr = e_addr; b.be = e_be; b.wd = e_wd;
        bus_q.push_back(b);
        d.rd = e_rd; d.err = !ack_en;
        done_q.push_back(d);
        @(negedge clk);
        chk({nm, "_fault"}, 32'(AccFaultM), 32'd0);
        chk({nm, "_idle_req"}, 32'(bus_req), 32'd0);
        stalls = 0;
        reqs   = 0;
        for (int c = 0; c < 40; c++) begin
            if (!StallM) break;
            stalls++;
            if (bus_req) reqs++;
            tick();
            bus_ack = ack_en && (stalls - 1 == dly);
            @(negedge clk);
        end
        bus_ack = 1'b0;
        chk({nm, "_released"}, 32'(StallM), 32'd0);
        chk({nm, "_stalls"}, stalls, ack_en ? dly + 2 : 5);
        chk({nm, "_req_cycles"}, reqs, ack_en ? dly + 1 : 4);
    endtask

    // An access that must fault with no bus activity.
    task automatic do_fault(input string nm, input logic we,
                            input logic [1:0] rs, input logic [31:0] a,
                            input logic [2:0] f3);
        tick();
        drive(we, rs, a, 32'h12345678, f3);
        @(negedge clk);
        chk({nm, "_fault"}, 32'(AccFaultM), 32'd1);
        chk({nm, "_stall"}, 32'(StallM), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk({nm, "_no_req"}, 32'(bus_req), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus_ack = 1'b0;
        bus_rdata = 32'd0;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 3'd0);
        tick();
        tick();
        @(negedge clk);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_buserr", 32'(BusErrM), 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        tick();
        reset = 1'b0;

        do_access("lw0", 1'b0, 2'b01, 32'h3000, 32'd0, 3'b010,
                  1'b1, 0, 32'h11223344, 32'h3000, 4'b1111, 32'd0,
                  32'h11223344);

        // Reset during WAIT, then a late ack that must be ignored.
        tick();
        drive(1'b0, 2'b01, 32'h3004, 32'd0, 3'b010);
        begin
            bus_exp_t b;
            b.we = 1'b0; b.addr = 32'h3004; b.be = 4'b1111; b.wd = 0;
            bus_q.push_back(b);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 3'd0);
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstw_req", 32'(bus_req), 32'd0);
        chk("rstw_stall", 32'(StallM), 32'd0);
        chk("rstw_rdata", ReadDataM, 32'd0);
        tick();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("rstw_req2", 32'(bus_req), 32'd0);
        chk("rstw_rdata2", ReadDataM, 32'd0);

        do_access("sb", 1'b1, 2'b00, 32'h1003, 32'h000000A5, 3'b000,
                  1'b1, 1, 32'd0, 32'h1000, 4'b1000, 32'hA5A5A5A5,
                  32'd0);
        do_access("lb", 1'b0, 2'b01, 32'h2002, 32'd0, 3'b000,
                  1'b1, 0, 32'h0080FF00, 32'h2000, 4'b0100, 32'd0,
                  32'hFFFFFF80);
        do_access("lbu", 1'b0, 2'b01, 32'h2002, 32'd0, 3'b100,
                  1'b1, 0, 32'h0080FF00, 32'h2000, 4'b0100, 32'd0,
                  32'h00000080);
        do_access("lh", 1'b0, 2'b01, 32'h2002, 32'd0, 3'b001,
                  1'b1, 0, 32'h80010000, 32'h2000, 4'b1100, 32'd0,
                  32'hFFFF8001);
        do_access("lhu", 1'b0, 2'b01, 32'h2002, 32'd0, 3'b101,
                  1'b1, 0, 32'h80010000, 32'h2000, 4'b1100, 32'd0,
                  32'h00008001);
        do_access("sh", 1'b1, 2'b00, 32'h2002, 32'h1234ABCD, 3'b001,
                  1'b1, 2, 32'd0, 32'h2000, 4'b1100, 32'hABCDABCD,
                  32'h00008001);

        do_fault("lw_mis", 1'b0, 2'b01, 32'h3006, 3'b010);
        do_fault("ld_f3", 1'b0, 2'b01, 32'h3000, 3'b011);
        do_fault("sh_mis", 1'b1, 2'b00, 32'h2001, 3'b001);
        do_fault("sbu_ill", 1'b1, 2'b00, 32'h2000, 3'b100);

        do_access("sw_tmo", 1'b1, 2'b00, 32'h4000, 32'h55AA1234,
                  3'b010, 1'b0, 0, 32'd0, 32'h4000, 4'b1111,
                  32'h55AA1234, 32'd0);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 3'd0);
        @(negedge clk);
        chk("tmo_err_clear", 32'(BusErrM), 32'd0);

        do_access("ack_wins", 1'b0, 2'b01, 32'h6008, 32'd0, 3'b010,
                  1'b1, 3, 32'h0BADF00D, 32'h6008, 4'b1111, 32'd0,
                  32'h0BADF00D);
        do_access("lw_fast", 1'b0, 2'b01, 32'h5000, 32'd0, 3'b010,
                  1'b1, 0, 32'hDEADBEEF, 32'h5000, 4'b1111, 32'd0,
                  32'hDEADBEEF);
        do_access("sw_b2b", 1'b1, 2'b01, 32'h5004, 32'h01020304,
                  3'b010, 1'b1, 0, 32'd0, 32'h5004, 4'b1111,
                  32'h01020304, 32'hDEADBEEF);

        // Ack while idle must not disturb anything.
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 3'd0);
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFFFFFF;
        tick();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_req", 32'(bus_req), 32'd0);
        chk("idle_ack_rdata", ReadDataM, 32'hDEADBEEF);

        tick();
        tick();
        chk("bus_q_left", bus_q.size(), 32'd0);
        chk("done_q_left", done_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
